// File: rtl/axis_pkt_pkg.sv
// Shared constants and helpers for the 8<->24 bit AXI4-Stream width converters.
// Lane geometry and the TKEEP pattern for partial words live here.
package axis_pkt_pkg;

  localparam int BYTE_W = 8;
  localparam int LANES  = 3;
  localparam int OUT_W  = BYTE_W * LANES;
  localparam int KEEP_W = LANES;
  localparam int IDX_W  = 2;

  // Valid lanes are 0..idx, mapped to the low or high end of the word.
  function automatic logic [KEEP_W-1:0] keep_mask(
    input logic [IDX_W-1:0] idx,
    input logic             lsb_first
  );
    logic [KEEP_W-1:0] m;
    m = '0;
    for (int i = 0; i < KEEP_W; i++) begin
      if (i <= int'(idx)) begin
        if (lsb_first) m[i] = 1'b1;
        else           m[KEEP_W-1-i] = 1'b1;
      end
    end
    return m;
  endfunction

endpackage

// File: rtl/axis_out_reg.sv
// One-entry AXI4-Stream register slice carrying data, keep and last.
// Accepts a new beat whenever empty or being drained in the same cycle.
module axis_out_reg #(
  parameter int DATA_W = 24,
  parameter int KEEP_W = 3
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              s_valid_i,
  output logic              s_ready_o,
  input  logic [DATA_W-1:0] s_data_i,
  input  logic [KEEP_W-1:0] s_keep_i,
  input  logic              s_last_i,
  output logic              m_valid_o,
  input  logic              m_ready_i,
  output logic [DATA_W-1:0] m_data_o,
  output logic [KEEP_W-1:0] m_keep_o,
  output logic              m_last_o
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [KEEP_W-1:0] keep_q, keep_d;
  logic              last_q, last_d;

  assign s_ready_o = !valid_q || m_ready_i;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    keep_d  = keep_q;
    last_d  = last_q;
    if (s_ready_o) begin
      valid_d = s_valid_i;
      if (s_valid_i) begin
        data_d = s_data_i;
        keep_d = s_keep_i;
        last_d = s_last_i;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      keep_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      keep_q  <= keep_d;
      last_q  <= last_d;
    end
  end

  assign m_valid_o = valid_q;
  assign m_data_o  = data_q;
  assign m_keep_o  = keep_q;
  assign m_last_o  = last_q;

endmodule

// File: rtl/axis_pixel_packer_8to24.sv
// Packs three consecutive stream bytes into one 24-bit AXI4-Stream word.
// Frames ending mid-word are flushed zero-padded with TKEEP marking valid lanes.
module axis_pixel_packer_8to24
  import axis_pkt_pkg::*;
#(
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic              ap_clk,
  input  logic              ap_rst,
  input  logic [BYTE_W-1:0] stream_in_TDATA,
  input  logic              stream_in_TLAST,
  input  logic              stream_in_TVALID,
  output logic              stream_in_TREADY,
  output logic [OUT_W-1:0]  stream_out_TDATA,
  output logic [KEEP_W-1:0] stream_out_TKEEP,
  output logic              stream_out_TLAST,
  output logic              stream_out_TVALID,
  input  logic              stream_out_TREADY,
  output logic [15:0]       frame_count
);

  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [OUT_W-1:0]  asm_q, asm_d;
  logic [15:0]       frame_q, frame_d;
  logic [OUT_W-1:0]  word;
  logic              in_ready;
  logic              in_fire;
  logic              close;
  logic              out_fire;

  assign in_fire = stream_in_TVALID && in_ready;
  assign close   = in_fire &&
                   (idx_q == IDX_W'(LANES-1) || stream_in_TLAST);

  // Merge the incoming byte into its lane of the partial word.
  always_comb begin
    word = asm_q;
    for (int i = 0; i < LANES; i++) begin
      if (idx_q == IDX_W'(i)) begin
        if (LSB_FIRST)
          word[i*BYTE_W +: BYTE_W] = stream_in_TDATA;
        else
          word[(LANES-1-i)*BYTE_W +: BYTE_W] = stream_in_TDATA;
      end
    end
  end

  always_comb begin
    idx_d = idx_q;
    asm_d = asm_q;
    if (in_fire) begin
      if (close) begin
        idx_d = '0;
        asm_d = '0;
      end else begin
        idx_d = idx_q + IDX_W'(1);
        asm_d = word;
      end
    end
  end

  assign out_fire = stream_out_TVALID && stream_out_TREADY;

  always_comb begin
    frame_d = frame_q;
    if (out_fire && stream_out_TLAST)
      frame_d = frame_q + 16'd1;
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      idx_q   <= '0;
      asm_q   <= '0;
      frame_q <= '0;
    end else begin
      idx_q   <= idx_d;
      asm_q   <= asm_d;
      frame_q <= frame_d;
    end
  end

  axis_out_reg #(
    .DATA_W(OUT_W),
    .KEEP_W(KEEP_W)
  ) u_out (
    .clk_i    (ap_clk),
    .rst_i    (ap_rst),
    .s_valid_i(close),
    .s_ready_o(in_ready),
    .s_data_i (word),
    .s_keep_i (keep_mask(idx_q, LSB_FIRST)),
    .s_last_i (stream_in_TLAST),
    .m_valid_o(stream_out_TVALID),
    .m_ready_i(stream_out_TREADY),
    .m_data_o (stream_out_TDATA),
    .m_keep_o (stream_out_TKEEP),
    .m_last_o (stream_out_TLAST)
  );

  assign stream_in_TREADY = in_ready;
  assign frame_count      = frame_q;

endmodule

// File: tb/tb_axis_pixel_packer_8to24.sv
// Scoreboard bench for the 8->24 packer: LSB-first and MSB-first instances.
// Directed vectors push expected words; a negedge monitor pops and compares.
module tb_axis_pixel_packer_8to24;

  typedef struct packed {
    logic [23:0] d;
    logic [2:0]  k;
    logic        l;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [7:0]  in_data = '0;
  logic        in_last = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [23:0] out_data;
  logic [2:0]  out_keep;
  logic        out_last;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] fc;

  logic [7:0]  b_in_data = '0;
  logic        b_in_last = 1'b0;
  logic        b_in_valid = 1'b0;
  logic        b_in_ready;
  logic [23:0] b_out_data;
  logic [2:0]  b_out_keep;
  logic        b_out_last;
  logic        b_out_valid;
  logic        b_out_ready = 1'b1;
  logic [15:0] b_fc;

  axis_pixel_packer_8to24 #(.LSB_FIRST(1'b1)) dut (
    .ap_clk           (clk),
    .ap_rst           (rst),
    .stream_in_TDATA  (in_data),
    .stream_in_TLAST  (in_last),
    .stream_in_TVALID (in_valid),
    .stream_in_TREADY (in_ready),
    .stream_out_TDATA (out_data),
    .stream_out_TKEEP (out_keep),
    .stream_out_TLAST (out_last),
    .stream_out_TVALID(out_valid),
    .stream_out_TREADY(out_ready),
    .frame_count      (fc)
  );

  axis_pixel_packer_8to24 #(.LSB_FIRST(1'b0)) dut_msb (
    .ap_clk           (clk),
    .ap_rst           (rst),
    .stream_in_TDATA  (b_in_data),
    .stream_in_TLAST  (b_in_last),
    .stream_in_TVALID (b_in_valid),
    .stream_in_TREADY (b_in_ready),
    .stream_out_TDATA (b_out_data),
    .stream_out_TKEEP (b_out_keep),
    .stream_out_TLAST (b_out_last),
    .stream_out_TVALID(b_out_valid),
    .stream_out_TREADY(b_out_ready),
    .frame_count      (b_fc)
  );

  exp_t q0[$];
  exp_t q1[$];
  int   errors = 0;
  int   checks = 0;
  int   rdy_mode = 0;
  int   cyc = 0;
  int   bubbles = 0;
  logic t4 = 1'b0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // 0: always ready, 1: toggle every cycle, 2: stalled
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ~out_ready;
      default: out_ready = 1'b0;
    endcase
  end

  exp_t e0, e1, prev;
  logic prev_stall = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      chk("in_ready", 32'(in_ready), 32'(!(out_valid && !out_ready)));
      if (prev_stall) begin
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_word", 32'({out_data, out_keep, out_last}), 32'(prev));
      end
      if (out_valid && out_ready) begin
        if (q0.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word: got %h with empty queue", out_data);
        end else begin
          e0 = q0.pop_front();
          chk("word", 32'({out_data, out_keep, out_last}), 32'(e0));
        end
      end
      prev_stall = out_valid && !out_ready;
      prev = {out_data, out_keep, out_last};
      if (b_out_valid && b_out_ready) begin
        if (q1.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_msb_word: got %h with empty queue", b_out_data);
        end else begin
          e1 = q1.pop_front();
          chk("msb_word", 32'({b_out_data, b_out_keep, b_out_last}), 32'(e1));
        end
      end
      if (t4 && in_valid && !in_ready) bubbles++;
    end
  end

  task automatic send(input bit which, input logic [7:0] b, input logic l);
    int   n;
    logic acc;
    if (which) begin
      b_in_valid = 1'b1; b_in_data = b; b_in_last = l;
    end else begin
      in_valid = 1'b1; in_data = b; in_last = l;
    end
    n = 0;
    acc = 1'b0;
    do begin
      @(negedge clk);
      acc = which ? b_in_ready : in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 200);
    if (!acc) chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle();
    in_valid = 1'b0; in_last = 1'b0;
    b_in_valid = 1'b0; b_in_last = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 300) begin
      @(posedge clk);
      n++;
    end
    chk("drain", 32'(q0.size() + q1.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t mk(input logic [23:0] d, input logic [2:0] k,
                              input logic l);
    exp_t x;
    x.d = d; x.k = k; x.l = l;
    return x;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    logic [7:0] b0, b1, b2;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_keep", 32'(out_keep), 32'd0);
    chk("rst_last", 32'(out_last), 32'd0);
    chk("rst_fc", 32'(fc), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // T1 full word
    send(0, 8'h11, 1'b0);
    send(0, 8'h22, 1'b0);
    chk("t1_early", 32'(out_valid), 32'd0);
    q0.push_back(mk(24'h332211, 3'b111, 1'b1));
    send(0, 8'h33, 1'b1);
    chk("t1_latency", 32'(out_valid), 32'd1);
    idle();
    drain();
    chk("t1_fc", 32'(fc), 32'd1);

    // T2 partial flushes
    q0.push_back(mk(24'h00BBAA, 3'b011, 1'b1));
    send(0, 8'hAA, 1'b0);
    send(0, 8'hBB, 1'b1);
    q0.push_back(mk(24'h0000CC, 3'b001, 1'b1));
    send(0, 8'hCC, 1'b1);
    idle();
    drain();
    chk("t2_fc", 32'(fc), 32'd3);

    // T3 toggling backpressure
    rdy_mode = 1;
    q0.push_back(mk(24'hA3A2A1, 3'b111, 1'b0));
    q0.push_back(mk(24'hA6A5A4, 3'b111, 1'b0));
    q0.push_back(mk(24'hA9A8A7, 3'b111, 1'b1));
    for (int i = 0; i < 9; i++)
      send(0, 8'hA1 + 8'(i), i == 8);
    idle();
    drain();
    rdy_mode = 0;
    @(posedge clk);
    #1;
    chk("t3_fc", 32'(fc), 32'd4);

    // T4 sustained streaming
    t4 = 1'b1;
    c0 = cyc;
    for (int i = 0; i < 300; i++) begin
      if (i % 3 == 0) begin
        b0 = 8'(i); b1 = 8'(i + 1); b2 = 8'(i + 2);
        q0.push_back(mk({b2, b1, b0}, 3'b111, ((i + 3) % 30) == 0));
      end
      send(0, 8'(i), ((i + 1) % 30) == 0);
    end
    chk("t4_cycles", 32'(cyc - c0), 32'd300);
    t4 = 1'b0;
    idle();
    drain();
    chk("t4_bubbles", 32'(bubbles), 32'd0);
    chk("t4_fc", 32'(fc), 32'd14);

    // T5 reset with a stalled word, then with a partial word
    rdy_mode = 2;
    @(posedge clk);
    #2;
    send(0, 8'h71, 1'b0);
    send(0, 8'h72, 1'b0);
    send(0, 8'h73, 1'b1);
    idle();
    chk("t5_stalled", 32'(out_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("t5_rst_valid", 32'(out_valid), 32'd0);
    chk("t5_rst_data", 32'(out_data), 32'd0);
    chk("t5_rst_keep", 32'(out_keep), 32'd0);
    chk("t5_rst_last", 32'(out_last), 32'd0);
    chk("t5_rst_fc", 32'(fc), 32'd0);
    rdy_mode = 0;
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    send(0, 8'h55, 1'b0);
    send(0, 8'h66, 1'b0);
    idle();
    #2 rst = 1'b1;
    #1;
    chk("t5_rst2_valid", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    q0.push_back(mk(24'h030201, 3'b111, 1'b1));
    send(0, 8'h01, 1'b0);
    send(0, 8'h02, 1'b0);
    send(0, 8'h03, 1'b1);
    idle();
    drain();
    chk("t5_fc", 32'(fc), 32'd1);

    // T6 MSB-first lane order
    q1.push_back(mk(24'h112200, 3'b110, 1'b1));
    send(1, 8'h11, 1'b0);
    send(1, 8'h22, 1'b1);
    idle();
    drain();
    chk("t6_fc", 32'(b_fc), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
